// File: rtl/sd_clk_generator.sv
// SD card clock divider with glitch-free divisor reload, gating and strobes.
// Ports: clk, reset (async low), count/load divisor request, clk_en, hold,
//   sd_clk, rise_stb, fall_stb, ready, err.
// Build option: define SD_CLK_GATE_EN to let hold park the clock.
module sd_clk_generator (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        load,
  input  logic        clk_en,
  input  logic        hold,
  output logic        sd_clk,
  output logic        rise_stb,
  output logic        fall_stb,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  localparam logic [15:0] DIV_RST = 16'd125;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic [15:0] pend_q;
  logic        pend_v;

  logic [15:0] hi_len;
  logic [15:0] lo_len;
  logic        gate;
  logic        run;
  logic        bound;
  logic        apply;
  logic        load_ok;

`ifdef SD_CLK_GATE_EN
  assign gate = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign gate = 1'b0;
`endif

  // odd divisors give the spare cycle to the low phase
  assign hi_len  = {1'b0, div_q[15:1]};
  assign lo_len  = div_q - hi_len;
  assign run     = clk_en & ~gate;
  assign bound   = (state_q == HIGH) && (cnt_q == hi_len);
  // divisor only changes where no phase is in flight
  assign apply   = pend_v && ((state_q == IDLE) || bound);
  assign load_ok = load && (count[15:1] != 15'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      pend_v   <= 1'b0;
      sd_clk   <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      ready    <= 1'b1;
      err      <= 1'b0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      err      <= load && !load_ok;

      if (apply) begin
        div_q  <= pend_q;
        pend_v <= 1'b0;
        ready  <= 1'b1;
      end
      // a load in the applying cycle waits for the next boundary
      if (load_ok) begin
        pend_q <= count;
        pend_v <= 1'b1;
        ready  <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          sd_clk <= 1'b0;
          if (run) begin
            state_q <= LOW;
            cnt_q   <= 16'd1;
          end
        end
        LOW: begin
          if (cnt_q == lo_len) begin
            state_q  <= HIGH;
            sd_clk   <= 1'b1;
            rise_stb <= 1'b1;
            cnt_q    <= 16'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        HIGH: begin
          if (bound) begin
            sd_clk   <= 1'b0;
            fall_stb <= 1'b1;
            if (run) begin
              state_q <= LOW;
              cnt_q   <= 16'd1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          sd_clk  <= 1'b0;
        end
      endcase
    end
  end

endmodule
